// File: rtl/osd_pkg.sv
// Shared definitions for the OSD tile sequencer: bus widths, command op
// encodings, SPI decode constants, engine FSM states and the command payload.
package osd_pkg;

  localparam int unsigned OSD_SPI_ADDR_W = 16;
  localparam int unsigned OSD_DATA_W     = 8;
  localparam int unsigned OSD_OP_W       = 2;
  localparam int unsigned OSD_ROW_W      = 5;

  localparam logic [OSD_OP_W-1:0] OSD_OP_CLEAR  = 2'b00;
  localparam logic [OSD_OP_W-1:0] OSD_OP_SCROLL = 2'b01;
  localparam logic [OSD_OP_W-1:0] OSD_OP_FILL   = 2'b10;

  localparam logic [7:0] OSD_EN_PAGE  = 8'hFE;
  localparam logic [1:0] OSD_TILE_SEL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_SCR_RD = 3'd2,
    ST_SCR_WR = 3'd3,
    ST_FILL   = 3'd4,
    ST_DONE   = 3'd5
  } osd_state_t;

  // Command latched at handshake.
  typedef struct packed {
    logic [OSD_OP_W-1:0]   op;
    logic [OSD_ROW_W-1:0]  row;
    logic [OSD_DATA_W-1:0] chr;
  } osd_cmd_t;

endpackage

// File: rtl/osd_tile_sequencer_if.sv
// Bus bundle of the tile sequencer: SPI write strobe, command handshake and
// the tile map write/read ports.
//   slave  : the sequencer side (consumes SPI/command, drives tile map)
//   master : the host/environment side
interface osd_tile_sequencer_if #(
  parameter int unsigned ADDR_W = 11
) ();
  import osd_pkg::*;

  logic                      spi_wr;
  logic [OSD_SPI_ADDR_W-1:0] spi_addr;
  logic [OSD_DATA_W-1:0]     spi_data;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [OSD_OP_W-1:0]       cmd_op;
  logic [OSD_ROW_W-1:0]      cmd_row;
  logic [OSD_DATA_W-1:0]     cmd_char;

  logic                      tm_we;
  logic [ADDR_W-1:0]         tm_waddr;
  logic [OSD_DATA_W-1:0]     tm_wdata;
  logic [ADDR_W-1:0]         tm_raddr;
  logic [OSD_DATA_W-1:0]     tm_rdata;

  modport slave (
    input  spi_wr, spi_addr, spi_data,
    input  cmd_valid, cmd_op, cmd_row, cmd_char,
    output cmd_ready,
    output tm_we, tm_waddr, tm_wdata, tm_raddr,
    input  tm_rdata
  );

  modport master (
    output spi_wr, spi_addr, spi_data,
    output cmd_valid, cmd_op, cmd_row, cmd_char,
    input  cmd_ready,
    input  tm_we, tm_waddr, tm_wdata, tm_raddr,
    output tm_rdata
  );

endinterface

// File: rtl/osd_wr_arb.sv
// SPI address decode plus registered priority mux for the tile map write port.
// SPI tile writes always win; the engine sees eng_grant_c low and retries.
// Ports:
//   clk_pixel, reset           : clock, synchronous active-high reset
//   spi_wr/spi_addr/spi_data   : SPI write strobe, byte address, data
//   eng_req/eng_addr/eng_data  : engine write request for this cycle
//   eng_grant_c                : engine write accepted this cycle (combinational)
//   tm_we/tm_waddr/tm_wdata    : registered tile map write port
//   osd_en                     : registered overlay enable
module osd_wr_arb
  import osd_pkg::*;
#(
  parameter int unsigned c_chars_x = 64,
  parameter int unsigned c_chars_y = 24,
  parameter int unsigned c_init_on = 1,
  parameter int unsigned c_addr_w  = $clog2(c_chars_x * c_chars_y)
) (
  input  logic                      clk_pixel,
  input  logic                      reset,
  input  logic                      spi_wr,
  input  logic [OSD_SPI_ADDR_W-1:0] spi_addr,
  input  logic [OSD_DATA_W-1:0]     spi_data,
  input  logic                      eng_req,
  input  logic [c_addr_w-1:0]       eng_addr,
  input  logic [OSD_DATA_W-1:0]     eng_data,
  output logic                      eng_grant_c,
  output logic                      tm_we,
  output logic [c_addr_w-1:0]       tm_waddr,
  output logic [OSD_DATA_W-1:0]     tm_wdata,
  output logic                      osd_en
);

  localparam int unsigned N_CELLS = c_chars_x * c_chars_y;

  logic [c_addr_w-1:0] spi_idx_c;
  logic                en_wr_c;
  logic                tile_wr_c;

  // Enable page takes precedence over the tile window it overlaps.
  assign spi_idx_c   = spi_addr[c_addr_w-1:0];
  assign en_wr_c     = spi_wr && (spi_addr[15:8] == OSD_EN_PAGE);
  assign tile_wr_c   = spi_wr && !en_wr_c && (spi_addr[15:14] == OSD_TILE_SEL)
                       && (32'(spi_idx_c) < N_CELLS);
  assign eng_grant_c = eng_req && !tile_wr_c;

  // Registered write port; address/data hold when idle.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      tm_we    <= 1'b0;
      tm_waddr <= '0;
      tm_wdata <= '0;
      osd_en   <= 1'(c_init_on);
    end else begin
      if (en_wr_c) begin
        osd_en <= spi_data[0];
      end
      if (tile_wr_c) begin
        tm_we    <= 1'b1;
        tm_waddr <= spi_idx_c;
        tm_wdata <= spi_data;
      end else if (eng_req) begin
        tm_we    <= 1'b1;
        tm_waddr <= eng_addr;
        tm_wdata <= eng_data;
      end else begin
        tm_we    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/osd_tile_sequencer.sv
// OSD tile map controller: command engine (clear / scroll-up / row fill)
// sharing the tile map write port with the SPI slave via osd_wr_arb.
// Ports:
//   clk_pixel, reset : pixel clock, synchronous active-high reset
//   bus              : SPI, command handshake and tile map ports (slave side)
//   osd_en           : overlay enable register
//   busy             : engine not idle
//   done             : one-cycle pulse on command completion
module osd_tile_sequencer
  import osd_pkg::*;
#(
  parameter int unsigned c_chars_x = 64,
  parameter int unsigned c_chars_y = 24,
  parameter int unsigned c_init_on = 1,
  parameter int unsigned c_addr_w  = $clog2(c_chars_x * c_chars_y)
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  osd_tile_sequencer_if.slave  bus,
  output logic                 osd_en,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned N_CELLS = c_chars_x * c_chars_y;

  localparam logic [c_addr_w-1:0]  X_W        = c_addr_w'(c_chars_x);
  localparam logic [c_addr_w-1:0]  ONE_W      = c_addr_w'(1);
  localparam logic [c_addr_w-1:0]  LAST_CELL  = c_addr_w'(N_CELLS - 1);
  localparam logic [c_addr_w-1:0]  LAST_SRC   = c_addr_w'(N_CELLS - c_chars_x - 1);
  localparam logic [c_addr_w-1:0]  LAST_COL   = c_addr_w'(c_chars_x - 1);
  localparam logic [OSD_ROW_W-1:0] BOTTOM_ROW = OSD_ROW_W'(c_chars_y - 1);

  osd_state_t            state_q, state_d;
  osd_cmd_t              cmd_q, cmd_d;
  logic [c_addr_w-1:0]   cnt_q, cnt_d;
  logic [c_addr_w-1:0]   raddr_q, raddr_d;
  logic                  ready_q;

  logic                  eng_req_c;
  logic [c_addr_w-1:0]   eng_addr_c;
  logic [OSD_DATA_W-1:0] eng_data_c;
  logic                  eng_grant_c;
  logic [c_addr_w-1:0]   row_base_c;

  logic                  tm_we;
  logic [c_addr_w-1:0]   tm_waddr;
  logic [OSD_DATA_W-1:0] tm_wdata;

  assign row_base_c    = c_addr_w'(cmd_q.row) * X_W;
  assign bus.cmd_ready = ready_q;
  assign bus.tm_raddr  = raddr_q;
  assign bus.tm_we     = tm_we;
  assign bus.tm_waddr  = tm_waddr;
  assign bus.tm_wdata  = tm_wdata;

  // Next-state, counter and engine write request.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    raddr_d    = raddr_q;
    eng_req_c  = 1'b0;
    eng_addr_c = cnt_q;
    eng_data_c = cmd_q.chr;

    case (state_q)
      ST_IDLE: begin
        if (ready_q && bus.cmd_valid) begin
          cmd_d = '{op: bus.cmd_op, row: bus.cmd_row, chr: bus.cmd_char};
          cnt_d = '0;
          case (bus.cmd_op)
            OSD_OP_CLEAR:  state_d = ST_CLR;
            OSD_OP_SCROLL: begin
              state_d = ST_SCR_RD;
              raddr_d = X_W;
            end
            OSD_OP_FILL:   state_d = (32'(bus.cmd_row) < c_chars_y) ? ST_FILL : ST_DONE;
            default:       state_d = ST_DONE;
          endcase
        end
      end

      ST_CLR: begin
        eng_req_c = 1'b1;
        if (eng_grant_c) begin
          if (cnt_q == LAST_CELL) state_d = ST_DONE;
          else                    cnt_d   = cnt_q + ONE_W;
        end
      end

      // Read address already points at cnt+X; data arrives next cycle.
      ST_SCR_RD: state_d = ST_SCR_WR;

      // On preemption stay here: the read address is held, so rdata re-samples.
      ST_SCR_WR: begin
        eng_req_c  = 1'b1;
        eng_data_c = bus.tm_rdata;
        if (eng_grant_c) begin
          if (cnt_q == LAST_SRC) begin
            state_d   = ST_FILL;
            cmd_d.row = BOTTOM_ROW;
            cnt_d     = '0;
          end else begin
            state_d = ST_SCR_RD;
            cnt_d   = cnt_q + ONE_W;
            raddr_d = cnt_q + ONE_W + X_W;
          end
        end
      end

      ST_FILL: begin
        eng_req_c  = 1'b1;
        eng_addr_c = row_base_c + cnt_q;
        if (eng_grant_c) begin
          if (cnt_q == LAST_COL) state_d = ST_DONE;
          else                   cnt_d   = cnt_q + ONE_W;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      raddr_q <= '0;
      ready_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      ready_q <= (state_d == ST_IDLE);
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);
    end
  end

  osd_wr_arb #(
    .c_chars_x (c_chars_x),
    .c_chars_y (c_chars_y),
    .c_init_on (c_init_on),
    .c_addr_w  (c_addr_w)
  ) u_arb (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .spi_wr      (bus.spi_wr),
    .spi_addr    (bus.spi_addr),
    .spi_data    (bus.spi_data),
    .eng_req     (eng_req_c),
    .eng_addr    (eng_addr_c),
    .eng_data    (eng_data_c),
    .eng_grant_c (eng_grant_c),
    .tm_we       (tm_we),
    .tm_waddr    (tm_waddr),
    .tm_wdata    (tm_wdata),
    .osd_en      (osd_en)
  );

endmodule

// File: tb/tb_osd_tile_sequencer.sv
// Directed bench for osd_tile_sequencer at default geometry (64x24).
// The bench owns the tile map RAM (registered read, one-cycle latency).
module tb_osd_tile_sequencer;

  localparam int N = 1536;
  localparam int X = 64;

  logic clk_pixel = 1'b0;
  logic reset     = 1'b1;
  logic osd_en, busy, done;

  osd_tile_sequencer_if #(.ADDR_W(11)) bus ();

  osd_tile_sequencer dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus),
    .osd_en    (osd_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Tile map RAM model.
  logic [7:0] mem [0:2047];
  int wr_total = 0;
  always @(posedge clk_pixel) begin
    if (bus.tm_we) begin
      mem[bus.tm_waddr] <= bus.tm_wdata;
      wr_total <= wr_total + 1;
    end
    bus.tm_rdata <= mem[bus.tm_raddr];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_we;
    logic [10:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_en;
  } spi_vec_t;

  spi_vec_t vecs [10];

  // Issue a command and follow it until done or the cycle budget expires.
  // k counts cycles after the handshake edge.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] row, input logic [7:0] chr,
                         input bit trk, input int trk_base, input bit storm, input int budget,
                         output int done_at, output int eng_wr, output int order_err,
                         output int spi_n, output int spi_err);
    int exp_a;
    logic [10:0] sp_a;
    logic [7:0]  sp_d;
    bit chk_spi;
    done_at = -1; eng_wr = 0; order_err = 0; spi_n = 0; spi_err = 0;
    exp_a = trk_base; chk_spi = 0; sp_a = '0; sp_d = '0;
    @(negedge clk_pixel);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_row = row; bus.cmd_char = chr;
    @(negedge clk_pixel);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (k > 1) @(negedge clk_pixel);
      if (chk_spi) begin
        if (!(bus.tm_we && bus.tm_waddr == sp_a && bus.tm_wdata == sp_d)) spi_err++;
        chk_spi = 0;
      end else if (trk && bus.tm_we && bus.tm_wdata == chr) begin
        if (bus.tm_waddr != 11'(exp_a)) order_err++;
        exp_a++;
        eng_wr++;
      end
      if (done) begin
        done_at = k;
        break;
      end
      if (storm && (k % 3 == 0) && k <= 1500) begin
        sp_a = 11'((k * 5) % N);
        sp_d = 8'(128 + (k % 128));
        bus.spi_wr = 1'b1; bus.spi_addr = 16'hC000 | 16'(sp_a); bus.spi_data = sp_d;
        chk_spi = 1; spi_n++;
      end else begin
        bus.spi_wr = 1'b0;
      end
    end
    bus.spi_wr = 1'b0;
  endtask

  initial begin
    int d, e, o, sn, se, base, bad, w0;
    logic [7:0] ev;

    vecs[0] = '{16'hFE00, 8'h00, 1'b0, 11'd0,    8'h00, 1'b0};
    vecs[1] = '{16'hC005, 8'h41, 1'b1, 11'd5,    8'h41, 1'b0};
    vecs[2] = '{16'hC600, 8'h55, 1'b0, 11'd0,    8'h00, 1'b0};
    vecs[3] = '{16'hFE01, 8'h01, 1'b0, 11'd0,    8'h00, 1'b1};
    vecs[4] = '{16'h8005, 8'h77, 1'b0, 11'd0,    8'h00, 1'b1};
    vecs[5] = '{16'hC5FF, 8'h9A, 1'b1, 11'd1535, 8'h9A, 1'b1};
    vecs[6] = '{16'hFEFF, 8'h02, 1'b0, 11'd0,    8'h00, 1'b0};
    vecs[7] = '{16'hFE00, 8'h03, 1'b0, 11'd0,    8'h00, 1'b1};
    vecs[8] = '{16'hFF00, 8'h12, 1'b0, 11'd0,    8'h00, 1'b1};
    vecs[9] = '{16'hE005, 8'h13, 1'b1, 11'd5,    8'h13, 1'b1};

    bus.spi_wr = 1'b0; bus.spi_addr = '0; bus.spi_data = '0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_row = '0; bus.cmd_char = '0;

    // Reset state
    repeat (3) @(negedge clk_pixel);
    chk("rst_tm_we", 32'(bus.tm_we), 0);
    chk("rst_tm_waddr", 32'(bus.tm_waddr), 0);
    chk("rst_tm_wdata", 32'(bus.tm_wdata), 0);
    chk("rst_tm_raddr", 32'(bus.tm_raddr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("rst_osd_en", 32'(osd_en), 1);
    reset = 1'b0;
    @(negedge clk_pixel);
    chk("ready_after_rst", 32'(bus.cmd_ready), 1);

    // SPI decode table
    for (int v = 0; v < 10; v++) begin
      @(negedge clk_pixel);
      bus.spi_wr = 1'b1; bus.spi_addr = vecs[v].addr; bus.spi_data = vecs[v].data;
      @(negedge clk_pixel);
      bus.spi_wr = 1'b0;
      chk($sformatf("vec%0d_we", v), 32'(bus.tm_we), 32'(vecs[v].exp_we));
      if (vecs[v].exp_we) begin
        chk($sformatf("vec%0d_waddr", v), 32'(bus.tm_waddr), 32'(vecs[v].exp_addr));
        chk($sformatf("vec%0d_wdata", v), 32'(bus.tm_wdata), 32'(vecs[v].exp_data));
      end
      chk($sformatf("vec%0d_osd_en", v), 32'(osd_en), 32'(vecs[v].exp_en));
    end

    // Uncontended clear
    run_cmd(2'b00, 5'd0, 8'h20, 1, 0, 0, 3000, d, e, o, sn, se);
    chk("clr_done_at", 32'(d), N + 1);
    chk("clr_eng_writes", 32'(e), N);
    chk("clr_order_err", 32'(o), 0);
    @(negedge clk_pixel);
    chk("clr_ready_after", 32'(bus.cmd_ready), 1);

    // Clear with an SPI tile write every third cycle
    run_cmd(2'b00, 5'd0, 8'h20, 1, 0, 1, 4000, d, e, o, sn, se);
    chk("storm_spi_err", 32'(se), 0);
    chk("storm_eng_writes", 32'(e), N);
    chk("storm_order_err", 32'(o), 0);
    chk("storm_done_at", 32'(d), 32'(N + 1 + sn));

    // Preload cell = index[7:0] via SPI, back to back
    for (int i = 0; i < N; i++) begin
      @(negedge clk_pixel);
      bus.spi_wr = 1'b1; bus.spi_addr = 16'hC000 | 16'(i); bus.spi_data = 8'(i);
    end
    @(negedge clk_pixel);
    bus.spi_wr = 1'b0;
    @(negedge clk_pixel);

    // Scroll up with 0x2E into the vacated row
    run_cmd(2'b01, 5'd0, 8'h2E, 0, 0, 0, 4000, d, e, o, sn, se);
    chk("scr_done_at", 32'(d), 2 * (N - X) + X + 1);
    repeat (2) @(negedge clk_pixel);
    chk("scr_cell0", 32'(mem[0]), 32'h40);
    chk("scr_cell1471", 32'(mem[1471]), 32'hFF);
    chk("scr_cell1472", 32'(mem[1472]), 32'h2E);
    bad = 0;
    for (int i = 0; i < N; i++) begin
      ev = (i < N - X) ? 8'(i + X) : 8'h2E;
      if (mem[i] !== ev) bad++;
    end
    chk("scr_map_mismatches", 32'(bad), 0);

    // Fill row 3
    base = 3 * X;
    run_cmd(2'b10, 5'd3, 8'h55, 1, base, 0, 200, d, e, o, sn, se);
    chk("fill_done_at", 32'(d), X + 1);
    chk("fill_eng_writes", 32'(e), X);
    chk("fill_order_err", 32'(o), 0);
    repeat (2) @(negedge clk_pixel);
    chk("fill_cell191", 32'(mem[191]), 32'hFF);
    chk("fill_cell192", 32'(mem[192]), 32'h55);
    chk("fill_cell255", 32'(mem[255]), 32'h55);
    chk("fill_cell256", 32'(mem[256]), 32'h40);

    // Fill of an out-of-range row: immediate done, no writes
    w0 = wr_total;
    run_cmd(2'b10, 5'd30, 8'h66, 0, 0, 0, 4, d, e, o, sn, se);
    chk("fill30_done_in_2", 32'(d >= 1 && d <= 2), 1);
    repeat (2) @(negedge clk_pixel);
    chk("fill30_no_writes", 32'(wr_total - w0), 0);

    // Reserved op: no-op completion
    w0 = wr_total;
    run_cmd(2'b11, 5'd0, 8'h77, 0, 0, 0, 4, d, e, o, sn, se);
    chk("rsv_done_in_2", 32'(d >= 1 && d <= 2), 1);
    repeat (2) @(negedge clk_pixel);
    chk("rsv_no_writes", 32'(wr_total - w0), 0);

    // Reset in the middle of a scroll
    run_cmd(2'b01, 5'd0, 8'h2E, 0, 0, 0, 100, d, e, o, sn, se);
    chk("midscr_still_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk_pixel);
    chk("midscr_rst_busy", 32'(busy), 0);
    chk("midscr_rst_we", 32'(bus.tm_we), 0);
    reset = 1'b0;
    @(negedge clk_pixel);
    chk("midscr_ready", 32'(bus.cmd_ready), 1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || busy || bus.tm_we) bad++;
      @(negedge clk_pixel);
    end
    chk("midscr_quiet_after", 32'(bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
